// File: rtl/layernorm_scale_shift_if.sv
// Stream, coefficient-config and status signals of the LayerNorm scale/shift stage.
// The master side feeds products and coefficients; the slave side is the stage itself.
interface layernorm_scale_shift_if #(
    parameter int PROD_W = 37,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int N_CHAN = 8
);
    localparam int CH_W = $clog2(N_CHAN);

    logic                     frame_clr;
    logic signed [PROD_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_addr;
    logic signed [COEF_W-1:0] cfg_gamma;
    logic signed [COEF_W-1:0] cfg_beta;
    logic                     sat_seen;

    modport master (
        output frame_clr, in_data, in_valid, out_ready,
        output cfg_we, cfg_addr, cfg_gamma, cfg_beta,
        input  in_ready, out_data, out_valid, out_last, sat_seen
    );

    modport slave (
        input  frame_clr, in_data, in_valid, out_ready,
        input  cfg_we, cfg_addr, cfg_gamma, cfg_beta,
        output in_ready, out_data, out_valid, out_last, sat_seen
    );
endinterface

// File: rtl/layernorm_scale_shift.sv
// LayerNorm affine tail: round/saturate the normalize product, then apply per-channel gamma/beta.
// Two-cycle latency, one element per clock; both stages freeze while out_valid & ~out_ready, which also drops in_ready.
module layernorm_scale_shift #(
    parameter int PROD_W     = 37,
    parameter int SHIFT      = 15,
    parameter int MID_W      = 16,
    parameter int COEF_W     = 16,
    parameter int GAMMA_FRAC = 10,
    parameter int OUT_W      = 16,
    parameter int N_CHAN     = 8
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    layernorm_scale_shift_if.slave bus
);
    localparam int CH_W = $clog2(N_CHAN);
    localparam int R1_W = PROD_W + 1;
    localparam int P_W  = MID_W + COEF_W;
    localparam int R2_W = P_W + 2;

    localparam logic [CH_W-1:0]          LAST_CH  = CH_W'(N_CHAN - 1);
    localparam logic signed [R1_W-1:0]   RND1     = R1_W'(1) <<< (SHIFT - 1);
    localparam logic signed [R1_W-1:0]   MID_HI1  = R1_W'((1 << (MID_W - 1)) - 1);
    localparam logic signed [R1_W-1:0]   MID_LO1  = R1_W'(-(1 << (MID_W - 1)));
    localparam logic signed [R2_W-1:0]   RND2     = R2_W'(1) <<< (GAMMA_FRAC - 1);
    localparam logic signed [R2_W-1:0]   OUT_HI2  = R2_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [R2_W-1:0]   OUT_LO2  = R2_W'(-(1 << (OUT_W - 1)));
    localparam logic signed [MID_W-1:0]  MID_MAX  = {1'b0, {(MID_W-1){1'b1}}};
    localparam logic signed [MID_W-1:0]  MID_MIN  = {1'b1, {(MID_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0]  OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0]  OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] GAMMA_ONE = COEF_W'(1 << GAMMA_FRAC);

    logic signed [COEF_W-1:0] gamma_q [N_CHAN];
    logic signed [COEF_W-1:0] beta_q  [N_CHAN];

    logic [CH_W-1:0]          ch_cnt;
    logic [CH_W-1:0]          ch_cur;
    logic                     adv;
    logic                     accept;

    logic                     s1_valid;
    logic signed [MID_W-1:0]  s1_m;
    logic signed [COEF_W-1:0] s1_gamma;
    logic signed [COEF_W-1:0] s1_beta;
    logic                     s1_last;

    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic                     out_last_q;
    logic                     sat_q;

    logic signed [R1_W-1:0]   s1_sum;
    logic signed [R1_W-1:0]   s1_shr;
    logic signed [MID_W-1:0]  m_next;
    logic                     ovf1;

    logic signed [P_W-1:0]    prod;
    logic signed [R2_W-1:0]   q_sum;
    logic signed [R2_W-1:0]   q_shr;
    logic signed [R2_W-1:0]   r_sum;
    logic signed [OUT_W-1:0]  r_next;
    logic                     ovf2;

    assign adv          = bus.out_ready | ~out_valid_q;
    assign accept       = bus.in_valid & adv;
    // A clear coinciding with an accept tags that element as channel 0.
    assign ch_cur       = bus.frame_clr ? '0 : ch_cnt;

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sat_seen  = sat_q;

    always_comb begin
        s1_sum = R1_W'(bus.in_data) + RND1;
        s1_shr = s1_sum >>> SHIFT;
        ovf1   = 1'b0;
        m_next = s1_shr[MID_W-1:0];
        if (s1_shr > MID_HI1) begin
            ovf1   = 1'b1;
            m_next = MID_MAX;
        end else if (s1_shr < MID_LO1) begin
            ovf1   = 1'b1;
            m_next = MID_MIN;
        end
    end

    always_comb begin
        prod   = s1_m * s1_gamma;
        q_sum  = R2_W'(prod) + RND2;
        q_shr  = q_sum >>> GAMMA_FRAC;
        r_sum  = q_shr + R2_W'(s1_beta);
        ovf2   = 1'b0;
        r_next = r_sum[OUT_W-1:0];
        if (r_sum > OUT_HI2) begin
            ovf2   = 1'b1;
            r_next = OUT_MAX;
        end else if (r_sum < OUT_LO2) begin
            ovf2   = 1'b1;
            r_next = OUT_MIN;
        end
    end

    // The table read in stage 1 sees the pre-write value, so a same-cycle write applies from the next element.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < N_CHAN; i++) begin
                gamma_q[i] <= GAMMA_ONE;
                beta_q[i]  <= '0;
            end
        end else if (bus.cfg_we) begin
            gamma_q[bus.cfg_addr] <= bus.cfg_gamma;
            beta_q[bus.cfg_addr]  <= bus.cfg_beta;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ch_cnt      <= '0;
            s1_valid    <= 1'b0;
            s1_m        <= '0;
            s1_gamma    <= '0;
            s1_beta     <= '0;
            s1_last     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            if (accept) begin
                ch_cnt <= (ch_cur == LAST_CH) ? '0 : CH_W'(ch_cur + 1'b1);
            end else if (bus.frame_clr) begin
                ch_cnt <= '0;
            end

            if (adv) begin
                s1_valid    <= accept;
                out_valid_q <= s1_valid;
                if (accept) begin
                    s1_m     <= m_next;
                    s1_gamma <= gamma_q[ch_cur];
                    s1_beta  <= beta_q[ch_cur];
                    s1_last  <= (ch_cur == LAST_CH);
                end
                if (s1_valid) begin
                    out_data_q <= r_next;
                    out_last_q <= s1_last;
                end
            end

            sat_q <= (sat_q & ~bus.frame_clr) | (accept & ovf1) | (adv & s1_valid & ovf2);
        end
    end
endmodule

// File: tb/tb_layernorm_scale_shift.sv
// Directed bench for layernorm_scale_shift: fixed vectors with hand-worked results,
// plus a small coefficient model for the streamed bursts.
module tb_layernorm_scale_shift;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   gam_tb [8];
    int   bet_tb [8];

    layernorm_scale_shift_if bus ();

    layernorm_scale_shift dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int m, input int g, input int b);
        longint p;
        longint q;
        longint r;
        p = longint'(m) * longint'(g);
        q = (p + 512) >>> 10;
        r = q + longint'(b);
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic cfg(input int addr, input int g, input int b);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(addr);
        bus.cfg_gamma = 16'(g);
        bus.cfg_beta  = 16'(b);
        tick();
        bus.cfg_we    = 1'b0;
        gam_tb[addr]  = g;
        bet_tb[addr]  = b;
    endtask

    task automatic fclr();
        bus.frame_clr = 1'b1;
        tick();
        bus.frame_clr = 1'b0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) begin
            gam_tb[i] = 1024;
            bet_tb[i] = 0;
        end
    endtask

    // One element with no backpressure: visible exactly two edges after it is presented.
    task automatic single(input string tag, input logic signed [36:0] d, input int exp_d, input bit exp_l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_early"}, bus.out_valid, 0);
        tick();
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_dat"}, bus.out_data, exp_d);
        chk({tag, "_last"}, bus.out_last, exp_l);
        tick();
    endtask

    // Back-to-back stream starting at channel 0; optional same-cycle coefficient write at element cfg_k.
    task automatic burst(input string tag, input int n, input bit fixed_m, input int cfg_k, input int cfg_g);
        int e_d [32];
        bit e_l [32];
        int ch;
        int m;
        logic signed [36:0] d;
        ch = 0;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                m = fixed_m ? 3 : k + 1;
                d = 37'(m);
                bus.in_valid = 1'b1;
                bus.in_data  = d <<< 15;
                e_d[k] = model(m, gam_tb[ch], bet_tb[ch]);
                e_l[k] = (ch == 7);
                if (k == cfg_k) begin
                    bus.cfg_we    = 1'b1;
                    bus.cfg_addr  = 3'(ch);
                    bus.cfg_gamma = 16'(cfg_g);
                    bus.cfg_beta  = 16'(bet_tb[ch]);
                    gam_tb[ch]    = cfg_g;
                end
                ch = (ch + 1) % 8;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            bus.cfg_we = 1'b0;
            if (k >= 1) begin
                chk($sformatf("%s_vld%0d", tag, k - 1), bus.out_valid, 1);
                chk($sformatf("%s_dat%0d", tag, k - 1), bus.out_data, e_d[k-1]);
                chk($sformatf("%s_last%0d", tag, k - 1), bus.out_last, e_l[k-1]);
            end
        end
        tick();
        chk({tag, "_drained"}, bus.out_valid, 0);
    endtask

    initial begin
        int bp_exp [6];
        int sent;
        int got;
        bit stall;
        bit fire_in;
        bit fire_out;
        total = 0;
        bad   = 0;
        reset_model();
        rst_n         = 1'b0;
        bus.frame_clr = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_gamma = '0;
        bus.cfg_beta  = '0;
        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_sat_seen", bus.sat_seen, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        tick();

        // 3.0 * 1.0 + 5 on channel 0
        cfg(0, 1024, 5);
        single("basic", 37'sd98304, 8, 1'b0);

        // Round-half-up on channels 1..3 (gamma 1.0, beta 0)
        single("rnd_pos_half", 37'sd16384, 1, 1'b0);
        single("rnd_neg_half", -37'sd16384, 0, 1'b0);
        single("rnd_neg_more", -37'sd16385, -1, 1'b0);
        chk("sat_clear_before", bus.sat_seen, 0);

        // Channel 4 with beta 5: stage-1 clamps to 32767, stage-2 clamps again
        cfg(4, 1024, 5);
        single("sat_pos", {2'b01, 35'd0}, 32767, 1'b0);
        chk("sat_seen_pos", bus.sat_seen, 1);
        fclr();
        chk("sat_frame_clr", bus.sat_seen, 0);

        cfg(0, 1024, 0);
        single("sat_neg", {1'b1, 36'd0}, -32768, 1'b0);
        chk("sat_seen_neg", bus.sat_seen, 1);
        fclr();
        chk("sat_frame_clr2", bus.sat_seen, 0);

        // 20000 * 2.0 overflows only in stage 2
        cfg(0, 2048, 0);
        single("sat_stage2", 37'sd655360000, 32767, 1'b0);
        chk("sat_seen_stage2", bus.sat_seen, 1);

        cfg(0, 1024, 7);
        fclr();
        burst("wrap", 17, 1'b0, -1, 0);

        // Backpressure: out_ready low for cycles 3..6 of the stream
        fclr();
        for (int j = 0; j < 6; j++) bp_exp[j] = model(100 + j, gam_tb[j], bet_tb[j]);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            stall         = (cyc >= 3 && cyc < 7);
            bus.out_ready = !stall;
            bus.in_valid  = (sent < 6);
            bus.in_data   = 37'(100 + sent) <<< 15;
            #1;
            if (stall && bus.out_valid) begin
                chk($sformatf("bp_in_ready_c%0d", cyc), bus.in_ready, 0);
                chk($sformatf("bp_hold_c%0d", cyc), bus.out_data, bp_exp[got]);
            end
            fire_in  = bus.in_valid & bus.in_ready;
            fire_out = bus.out_valid & bus.out_ready;
            if (fire_out) begin
                chk($sformatf("bp_dat%0d", got), bus.out_data, bp_exp[got]);
                got++;
            end
            if (fire_in) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_count", got, 6);
        chk("bp_no_dup", bus.out_valid, 0);

        // Same-cycle write to channel 2 while accepting channel 2
        fclr();
        burst("cfgcorner", 11, 1'b1, 2, 2048);

        // Reset with two elements in flight
        fclr();
        bus.in_valid = 1'b1;
        bus.in_data  = 37'sd98304;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("inflight_vld", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", bus.out_valid, 0);
        chk("rst_mid_dat", bus.out_data, 0);
        tick();
        rst_n = 1'b1;
        reset_model();
        #1;
        chk("rst_mid_ready", bus.in_ready, 1);
        chk("rst_mid_sat", bus.sat_seen, 0);
        burst("postrst", 3, 1'b1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/layernorm_scale_shift.md
Name: layernorm_scale_shift

Overview:
- Streaming stage directly downstream of the LayerNorm normalize multiplier (22-bit signed centred value × 15-bit unsigned inverse std-dev → 37-bit signed product).
- Consumes one product per element, rounds and saturates it to the normalized width, then applies per-channel gamma/beta. This is the affine step that ends LayerNorm.
- Output feeds the next layer's input stream.
- Two-stage pipeline with valid/ready handshakes on both sides and a wrapping channel counter.

Parameters:
- PROD_W, 37: input product width, signed.
- SHIFT, 15: fractional bits removed from the product (inverse std-dev fraction bits).
- MID_W, 16: normalized intermediate width, signed.
- COEF_W, 16: gamma and beta width, signed.
- GAMMA_FRAC, 10: fractional bits of gamma.
- OUT_W, 16: output width, signed.
- N_CHAN, 8: channels per LayerNorm row, ≥2.

Ports:
- ap_clk, in, 1: clock.
- ap_rst_n, in, 1: asynchronous active-low reset.
- frame_clr, in, 1: synchronous clear of the channel counter and sat_seen.
- in_data, in, PROD_W: signed product.
- in_valid, in, 1: input valid.
- in_ready, out, 1: input ready.
- out_data, out, OUT_W: signed result.
- out_valid, out, 1: output valid.
- out_ready, in, 1: output ready.
- out_last, out, 1: asserted with the channel N_CHAN-1 element.
- cfg_we, in, 1: coefficient write strobe.
- cfg_addr, in, clog2(N_CHAN): channel to write.
- cfg_gamma, in, COEF_W: gamma value.
- cfg_beta, in, COEF_W: beta value.
- sat_seen, out, 1: sticky flag; any saturation in either stage.

Behaviour:
- Clock and reset: one clock, ap_clk. ap_rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, sat_seen=0.
  - Channel counter=0, both stage valids=0.
  - gamma[i]=1<<GAMMA_FRAC (1.0), beta[i]=0.
  - in_ready=1 immediately after reset is released.
- Pipeline advance: adv = out_ready | ~s2_valid. in_ready = adv.
  - Both stages shift together on adv; neither stage changes without adv.
  - Accept occurs when in_valid & in_ready.
- Stage 1, on accept:
  - m = (in_data + 2^(SHIFT-1)) >>> SHIFT, i.e. round-half-up arithmetic shift.
  - Saturate m to the signed MID_W range.
  - Capture gamma[ch], beta[ch], ch and last=(ch==N_CHAN-1) with the data.
  - s1_valid follows the accept. If adv is high with no accept, s1_valid goes to 0.
- Stage 2, on adv:
  - p = m*gamma at full 2*MID_W width.
  - q = (p + 2^(GAMMA_FRAC-1)) >>> GAMMA_FRAC.
  - r = q + sign-extended beta, computed wide enough that it cannot overflow.
  - Saturate r to the signed OUT_W range.
  - Drive out_data and out_last from the result; out_valid = s1_valid.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 element per clock.
- Backpressure: while out_valid & ~out_ready, out_data and out_last are held stable and in_ready=0.
- Channel counter:
  - Increments on each accept; wraps from N_CHAN-1 to 0.
  - frame_clr sets it to 0 and also clears sat_seen.
  - An accept in the same cycle as frame_clr is tagged with ch=0, and the counter becomes 1.
- Coefficient writes:
  - gamma/beta are written on cfg_we at cfg_addr.
  - An accept in the same cycle for the same channel uses the old value; the new value applies from the next cycle.
  - Elements already in flight keep the coefficients they captured.
- sat_seen:
  - Set in the cycle after any stage-1 or stage-2 saturation, but only on an advancing cycle (accept or adv).
  - Cleared only by reset or frame_clr; if a clear and a set occur in the same cycle, set wins.
- Reset mid-operation: all in-flight data is discarded, and the state returns to the reset values above, including coefficients.

Test Plan:
- Basic path: gamma[0]=1024, beta[0]=5; in_data=98304 (3.0) → out_data=8 two cycles after accept, out_last=0.
- Rounding:
  - in_data=16384 → stage-1 result 1.
  - in_data=-16384 → 0.
  - in_data=-16385 → -1.
  - All with gamma=1.0, beta=0.
- Saturation:
  - in_data=2^35 → stage-1 result 32767; with beta=5 → out_data=32767 and sat_seen=1.
  - frame_clr → sat_seen=0.
  - in_data=-2^36 → -32768.
- Channel wrap: 17 back-to-back inputs → out_last on outputs 8 and 16 only; the 17th output is tagged channel 0 and uses gamma[0]/beta[0].
- Backpressure: stream 6 inputs, hold out_ready=0 for 4 cycles mid-stream → in_ready=0 during the stall, out_data held stable, no loss or duplication, order preserved.
- Config/reset corner:
  - cfg_we to channel 2 in the same cycle as accepting channel 2 → the old gamma is used; the next row uses the new gamma.
  - Assert ap_rst_n low with 2 elements in flight → out_valid drops immediately, gamma returns to 1024.
